// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
// Package : rv_core_pkg
// Brief   : Shared RV32I opcode constants, fetch state encoding and helpers.
// Revision: 1.0
// ============================================================================
package rv_core_pkg;

  localparam int PC_W_DEFAULT = 11;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : rv_fetch_unit_if
// Brief     : ROM read port, redirect request and instruction handshake.
// Revision  : 1.0
// ============================================================================
interface rv_fetch_unit_if
  import rv_core_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
);
  logic [7:0]      rom_addr;
  logic [31:0]     rom_q;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_ready;
  logic            halt;

  modport fetch (
    output rom_addr, instr_valid, instr, instr_pc, halt,
    input  rom_q, redirect, redirect_pc, instr_ready
  );

  modport core (
    input  rom_addr, instr_valid, instr, instr_pc, halt,
    output rom_q, redirect, redirect_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : DEPTH-entry synchronous FIFO of {pc, instr} with single-cycle flush.
// Revision: 1.0
// ============================================================================
module fetch_queue #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_FULL);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count <= r_count + (c_AW+1)'(w_do_push) - (c_AW+1)'(w_do_pop);
    end
  end
endmodule
`default_nettype wire

// File: rtl/rv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : rv_fetch_unit
// Brief   : RV32I fetch stage: ROM issue/credit, redirect flush, illegal-op halt.
// Revision: 1.0
// ============================================================================
module rv_fetch_unit
  import rv_core_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  rv_fetch_unit_if.fetch bus
);
  localparam int              c_CW      = $clog2(DEPTH) + 1;
  localparam logic [c_CW:0]   c_DEPTH   = (c_CW+1)'(DEPTH);
  localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);

  fetch_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic            r_inflight;
  logic [PC_W-1:0] r_infl_pc;
  logic            r_infl_epoch;
  logic            r_epoch, w_epoch_nxt;
  logic            w_issue;
  logic [PC_W-1:0] w_issue_pc;

  logic [PC_W-1:0]    w_redir_pc;
  logic [PC_W+31:0]   w_q_dout;
  logic [c_CW-1:0]    w_q_count;
  logic               w_q_empty, w_q_full;
  logic               w_push, w_pop;
  logic [31:0]        w_head_instr;
  logic [PC_W-1:0]    w_head_pc;
  logic               w_head_illegal, w_instr_valid;
  logic               w_live_inflight, w_can_issue;
  logic [c_CW:0]      w_used, w_limit;

  assign w_redir_pc     = bus.redirect_pc & ~PC_W'(3);
  assign w_head_pc      = w_q_dout[PC_W+31:32];
  assign w_head_instr   = w_q_dout[31:0];
  assign w_head_illegal = (r_state == ST_RUN) && !w_q_empty && !is_legal_opcode(w_head_instr[6:0]);
  assign w_instr_valid  = (r_state == ST_RUN) && !w_q_empty && !w_head_illegal;
  assign w_pop          = w_instr_valid && bus.instr_ready && !bus.redirect;

  // A read whose epoch no longer matches was launched before a redirect.
  assign w_live_inflight = r_inflight && (r_infl_epoch == r_epoch);
  assign w_push          = w_live_inflight && (r_state == ST_RUN) && !w_head_illegal && !bus.redirect;

  assign w_used      = {1'b0, w_q_count} + {{c_CW{1'b0}}, w_live_inflight};
  assign w_limit     = c_DEPTH + {{c_CW{1'b0}}, w_pop};
  assign w_can_issue = (w_used < w_limit) && !(w_q_full && !w_pop);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_epoch_nxt    = r_epoch;
    w_issue        = 1'b0;
    w_issue_pc     = r_fetch_pc;
    if (bus.redirect) begin
      w_state_nxt    = ST_RUN;
      w_epoch_nxt    = ~r_epoch;
      w_issue        = 1'b1;
      w_issue_pc     = w_redir_pc;
      w_fetch_pc_nxt = w_redir_pc + c_PC_STEP;
    end else if (r_state == ST_RUN) begin
      if (w_head_illegal) begin
        w_state_nxt = ST_HALT;
      end else if (w_can_issue) begin
        w_issue        = 1'b1;
        w_fetch_pc_nxt = r_fetch_pc + c_PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_fetch_pc   <= RESET_PC;
      r_inflight   <= 1'b0;
      r_infl_pc    <= '0;
      r_infl_epoch <= 1'b0;
      r_epoch      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_inflight <= w_issue;
      r_epoch    <= w_epoch_nxt;
      if (w_issue) begin
        r_infl_pc    <= w_issue_pc;
        r_infl_epoch <= w_epoch_nxt;
      end
    end
  end

  fetch_queue #(
    .WIDTH (PC_W + 32),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   ({r_infl_pc, bus.rom_q}),
    .pop   (w_pop),
    .flush (bus.redirect),
    .dout  (w_q_dout),
    .count (w_q_count),
    .empty (w_q_empty),
    .full  (w_q_full)
  );

  assign bus.rom_addr    = bus.redirect ? w_redir_pc[9:2] : r_fetch_pc[9:2];
  assign bus.instr_valid = w_instr_valid;
  assign bus.instr       = w_q_empty ? 32'h0 : w_head_instr;
  assign bus.instr_pc    = w_q_empty ? '0 : w_head_pc;
  assign bus.halt        = (r_state == ST_HALT) || w_head_illegal;
endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_fetch_unit
// Brief   : Self-checking bench for rv_fetch_unit with a synchronous ROM model.
// Revision: 1.0
// ============================================================================
module tb_rv_fetch_unit;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rom [256];

  typedef struct {
    logic        ready;
    logic        valid;
    logic [10:0] pc;
  } vec_t;
  vec_t vt [13];

  rv_fetch_unit_if #(.PC_W(11)) bus ();

  rv_fetch_unit #(
    .PC_W     (11),
    .DEPTH    (2),
    .RESET_PC (11'h000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.fetch)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous instruction ROM.
  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  function automatic logic [31:0] rom_word(input logic [10:0] pc);
    return rom[pc[9:2]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rd, input logic [10:0] rpc);
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string nm, input logic v, input logic [10:0] pc);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.instr_valid), 32'(v));
    if (v) begin
      chk({nm, "_pc"}, 32'(bus.instr_pc), 32'(pc));
      chk({nm, "_instr"}, bus.instr, rom_word(pc));
    end
  endtask

  task automatic fill_rom();
    logic [6:0]  ops [7] = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67};
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w      = $urandom();
      w[6:0] = ops[$urandom_range(0, 6)];
      rom[i] = w;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 11'h000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", 32'(bus.instr_pc), 32'h0);
    chk("rst_halt", 32'(bus.halt), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        rdy, rd;
    logic [10:0] rpc, exp_pc;
    logic        prev_hold;
    int          since;

    drive(1'b1, 1'b0, 11'h000);
    fill_rom();

    vt[0]  = '{1'b1, 1'b0, 11'h000};
    vt[1]  = '{1'b1, 1'b0, 11'h000};
    vt[2]  = '{1'b1, 1'b1, 11'h000};
    vt[3]  = '{1'b1, 1'b1, 11'h004};
    vt[4]  = '{1'b0, 1'b1, 11'h008};
    vt[5]  = '{1'b0, 1'b1, 11'h008};
    vt[6]  = '{1'b0, 1'b1, 11'h008};
    vt[7]  = '{1'b0, 1'b1, 11'h008};
    vt[8]  = '{1'b0, 1'b1, 11'h008};
    vt[9]  = '{1'b1, 1'b1, 11'h008};
    vt[10] = '{1'b1, 1'b1, 11'h00C};
    vt[11] = '{1'b1, 1'b1, 11'h010};
    vt[12] = '{1'b1, 1'b1, 11'h014};

    // Stream from reset with a 5-cycle stall at 0x008.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive(vt[k].ready, 1'b0, 11'h000);
      look("tbl", vt[k].valid, vt[k].pc);
      next_cycle();
    end

    // Redirect beats the pop of 0x004; 0x008 never appears.
    do_reset();
    look("rd_k0", 1'b0, 11'h000); next_cycle();
    look("rd_k1", 1'b0, 11'h000); next_cycle();
    look("rd_k2", 1'b1, 11'h000); next_cycle();
    drive(1'b1, 1'b1, 11'h043);
    look("rd_pop", 1'b1, 11'h004);
    chk("rd_rom_addr", 32'(bus.rom_addr), 32'h10);
    next_cycle();
    drive(1'b1, 1'b0, 11'h000);
    look("rd_gap", 1'b0, 11'h000); next_cycle();
    look("rd_tgt", 1'b1, 11'h040); next_cycle();
    look("rd_tgt1", 1'b1, 11'h044); next_cycle();

    // Illegal word at 0x010 halts; redirect to 0x000 recovers.
    rom[4] = 32'h0000007F;
    do_reset();
    look("il_k0", 1'b0, 11'h000); next_cycle();
    look("il_k1", 1'b0, 11'h000); next_cycle();
    look("il_000", 1'b1, 11'h000); next_cycle();
    look("il_004", 1'b1, 11'h004); next_cycle();
    look("il_008", 1'b1, 11'h008); next_cycle();
    look("il_00c", 1'b1, 11'h00C); next_cycle();
    for (int k = 0; k < 4; k++) begin
      look("il_halted", 1'b0, 11'h000);
      chk("il_halt", 32'(bus.halt), 32'h1);
      chk("il_rom_addr", 32'(bus.rom_addr), 32'h06);
      next_cycle();
    end
    drive(1'b1, 1'b1, 11'h000);
    next_cycle();
    drive(1'b1, 1'b0, 11'h000);
    look("il_gap", 1'b0, 11'h000);
    chk("il_halt_clr", 32'(bus.halt), 32'h0);
    next_cycle();
    look("il_restart", 1'b1, 11'h000);
    chk("il_halt_run", 32'(bus.halt), 32'h0);
    next_cycle();
    rom[4] = {rom[4][31:7], 7'h13};

    // PC wrap from 0x7FC to 0x000.
    do_reset();
    look("wr_k0", 1'b0, 11'h000); next_cycle();
    look("wr_k1", 1'b0, 11'h000); next_cycle();
    drive(1'b1, 1'b1, 11'h7F8);
    look("wr_k2", 1'b1, 11'h000); next_cycle();
    drive(1'b1, 1'b0, 11'h000);
    look("wr_gap", 1'b0, 11'h000); next_cycle();
    look("wr_7f8", 1'b1, 11'h7F8); next_cycle();
    look("wr_7fc", 1'b1, 11'h7FC); next_cycle();
    look("wr_000", 1'b1, 11'h000); next_cycle();
    look("wr_004", 1'b1, 11'h004); next_cycle();

    // One-cycle reset pulse with two entries queued.
    do_reset();
    look("rp_k0", 1'b0, 11'h000); next_cycle();
    look("rp_k1", 1'b0, 11'h000); next_cycle();
    drive(1'b0, 1'b0, 11'h000);
    look("rp_k2", 1'b1, 11'h000); next_cycle();
    look("rp_k3", 1'b1, 11'h000); next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rp_valid_drop", 32'(bus.instr_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 11'h000);
    look("rp_r0", 1'b0, 11'h000); next_cycle();
    look("rp_r1", 1'b0, 11'h000); next_cycle();
    look("rp_000", 1'b1, 11'h000); next_cycle();
    look("rp_004", 1'b1, 11'h004); next_cycle();

    // Random ready/redirect against an in-order stream model.
    fill_rom();
    do_reset();
    exp_pc    = 11'h000;
    since     = 0;
    prev_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = 11'($urandom());
      drive(rdy, rd, rpc);
      @(negedge clk);
      if (prev_hold) chk("rnd_hold_valid", 32'(bus.instr_valid), 32'h1);
      if (since == 1) chk("rnd_redir_gap", 32'(bus.instr_valid), 32'h0);
      if (since == 2) chk("rnd_redir_fill", 32'(bus.instr_valid), 32'h1);
      if (bus.instr_valid) begin
        chk("rnd_pc", 32'(bus.instr_pc), 32'(exp_pc));
        chk("rnd_instr", bus.instr, rom_word(exp_pc));
      end
      chk("rnd_halt", 32'(bus.halt), 32'h0);
      prev_hold = bus.instr_valid & ~rdy & ~rd;
      if (rd) begin
        exp_pc = rpc & 11'h7FC;
        since  = 1;
      end else begin
        if (bus.instr_valid && rdy) exp_pc = exp_pc + 11'd4;
        if (since < 3) since++;
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
